// File: rtl/leaf_arb_pkg.sv
// Shared constants and output-slot state encoding for the leaf output arbiter.
package leaf_arb_pkg;
    localparam int INIT_CREDIT_DEFAULT   = 64;
    localparam int NUM_PORT_BITS_DEFAULT = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester after 'last', wrapping modulo NUM_PORTS.
module rr_pick #(
    parameter int NUM_PORTS     = 3,
    parameter int NUM_PORT_BITS = 4
) (
    input  logic [NUM_PORTS-1:0]     req,
    input  logic [NUM_PORT_BITS-1:0] last,
    output logic [NUM_PORTS-1:0]     gnt,
    output logic [NUM_PORT_BITS-1:0] gnt_idx,
    output logic                     any
);
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = NUM_PORT_BITS'(idx);
            end
        end
    end
endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin merge of NUM_PORTS credit-gated user streams into one port-tagged registered stream.
// One-cycle ack-to-valid latency; a new word may be granted in the same cycle the held one is accepted.
module leaf_out_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 3,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_PORT_BITS = NUM_PORT_BITS_DEFAULT,
    parameter int CREDIT_BITS   = 8,
    parameter int INIT_CREDIT   = INIT_CREDIT_DEFAULT
) (
    input  logic                              clk_user,
    input  logic                              reset,
    input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_PORTS-1:0]              vld_user,
    output logic [NUM_PORTS-1:0]              ack_user,
    output logic [PAYLOAD_BITS-1:0]           dout,
    output logic [NUM_PORT_BITS-1:0]          dout_port,
    output logic                              dout_vld,
    input  logic                              dout_ack,
    input  logic [NUM_PORTS-1:0]              credit_ret,
    output logic                              cred_err
);
    localparam logic [CREDIT_BITS-1:0] CRED_MAX = CREDIT_BITS'(INIT_CREDIT);
    localparam logic [CREDIT_BITS-1:0] CRED_ONE = CREDIT_BITS'(1);

    state_t                     state_q;
    logic [PAYLOAD_BITS-1:0]    dout_q;
    logic [PAYLOAD_BITS-1:0]    sel_dat;
    logic [NUM_PORT_BITS-1:0]   port_q;
    logic [NUM_PORT_BITS-1:0]   last_q;
    logic [NUM_PORT_BITS-1:0]   gnt_idx;
    logic [NUM_PORTS-1:0]       elig;
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS-1:0]       gnt;
    logic [NUM_PORTS-1:0]       ovf;
    logic                       any;
    logic                       slot_free;
    logic                       cred_err_q;

    // Reset also suppresses acks so no word is accepted that cannot be registered.
    assign slot_free = !reset && ((state_q == EMPTY) || dout_ack);
    assign req       = slot_free ? elig : '0;

    rr_pick #(
        .NUM_PORTS    (NUM_PORTS),
        .NUM_PORT_BITS(NUM_PORT_BITS)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .any    (any)
    );

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) sel_dat = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cred
        logic [CREDIT_BITS-1:0] credit_q;
        logic [CREDIT_BITS-1:0] credit_d;
        logic                   ovf_d;

        always_comb begin
            credit_d = credit_q;
            ovf_d    = 1'b0;
            if (gnt[i] && !credit_ret[i]) begin
                credit_d = credit_q - CRED_ONE;
            end else if (!gnt[i] && credit_ret[i]) begin
                if (credit_q == CRED_MAX) ovf_d = 1'b1;
                else                      credit_d = credit_q + CRED_ONE;
            end
        end

        always_ff @(posedge clk_user or posedge reset) begin
            if (reset) credit_q <= CRED_MAX;
            else       credit_q <= credit_d;
        end

        assign elig[i] = vld_user[i] && (credit_q != '0);
        assign ovf[i]  = ovf_d;
    end

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            dout_q     <= '0;
            port_q     <= '0;
            last_q     <= NUM_PORT_BITS'(NUM_PORTS - 1);
            cred_err_q <= 1'b0;
        end else begin
            if (any) begin
                state_q <= FULL;
                dout_q  <= sel_dat;
                port_q  <= gnt_idx;
                last_q  <= gnt_idx;
            end else if ((state_q == FULL) && dout_ack) begin
                state_q <= EMPTY;
            end
            cred_err_q <= cred_err_q | (|ovf);
        end
    end

    assign ack_user  = gnt;
    assign dout      = dout_q;
    assign dout_port = port_q;
    assign dout_vld  = (state_q == FULL);
    assign cred_err  = cred_err_q;
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter; expected words go into a scoreboard popped by an output monitor.
module tb_leaf_out_arbiter;
    logic        clk_user = 1'b0;
    logic        reset;
    logic [95:0] din_user;
    logic [2:0]  vld_user;
    logic [2:0]  ack_user;
    logic [31:0] dout;
    logic [3:0]  dout_port;
    logic        dout_vld;
    logic        dout_ack;
    logic [2:0]  credit_ret;
    logic        cred_err;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;
    logic [31:0] held;

    leaf_out_arbiter dut (
        .clk_user  (clk_user),
        .reset     (reset),
        .din_user  (din_user),
        .vld_user  (vld_user),
        .ack_user  (ack_user),
        .dout      (dout),
        .dout_port (dout_port),
        .dout_vld  (dout_vld),
        .dout_ack  (dout_ack),
        .credit_ret(credit_ret),
        .cred_err  (cred_err)
    );

    initial forever #5 clk_user = ~clk_user;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] mkdin(input int s);
        return {16'hC2C2, s[15:0], 16'hC1C1, s[15:0], 16'hC0C0, s[15:0]};
    endfunction

    // Drives one cycle from posedge+1, checks the ack at negedge and queues the granted word.
    task automatic cyc(input logic [2:0] vld, input logic ack, input logic [2:0] cret,
                       input logic [2:0] exp_ack, input string nm, input bit special = 0);
        exp_t e;
        seq++;
        din_user = mkdin(seq);
        if (special) din_user[63:32] = 32'hA5A5_0001;
        vld_user   = vld;
        dout_ack   = ack;
        credit_ret = cret;
        @(negedge clk_user);
        chk({nm, "_ack"}, 32'(ack_user), 32'(exp_ack));
        for (int p = 0; p < 3; p++) begin
            if (exp_ack[p]) begin
                e.d = din_user[p*32 +: 32];
                e.p = 4'(p);
                sb.push_back(e);
            end
        end
        @(posedge clk_user);
        #1;
        credit_ret = '0;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        sb.delete();
        #1;
        chk({nm, "_vld"},  32'(dout_vld),  32'd0);
        chk({nm, "_dout"}, dout,           32'd0);
        chk({nm, "_port"}, 32'(dout_port), 32'd0);
        chk({nm, "_ack"},  32'(ack_user),  32'd0);
        chk({nm, "_err"},  32'(cred_err),  32'd0);
        @(posedge clk_user);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk_user) begin
        if (!reset && dout_vld && dout_ack) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_dout", dout, e.d);
                chk("sb_port", 32'(dout_port), 32'(e.p));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        din_user   = '0;
        vld_user   = '0;
        dout_ack   = 1'b0;
        credit_ret = '0;
        @(posedge clk_user);
        #1;
        do_reset("rst0");

        // Round robin from reset: 0,1,2,0,1,2 back to back.
        cyc(3'b111, 1, 0, 3'b001, "rr0");
        cyc(3'b111, 1, 0, 3'b010, "rr1");
        cyc(3'b111, 1, 0, 3'b100, "rr2");
        cyc(3'b111, 1, 0, 3'b001, "rr3");
        cyc(3'b111, 1, 0, 3'b010, "rr4");
        cyc(3'b111, 1, 0, 3'b100, "rr5");

        // Single word from port 1.
        cyc(3'b010, 1, 0, 3'b010, "single", 1);
        chk("single_vld",  32'(dout_vld),  32'd1);
        chk("single_dout", dout,           32'hA5A5_0001);
        chk("single_port", 32'(dout_port), 32'd1);
        cyc(3'b000, 1, 0, 3'b000, "drain0");
        chk("drain0_vld", 32'(dout_vld), 32'd0);

        // Backpressure: held word stays, no acks, then regrant in the accept cycle.
        cyc(3'b111, 1, 0, 3'b100, "bp_fill");
        held = mkdin(seq) >> 64;
        for (int i = 0; i < 5; i++) begin
            cyc(3'b111, 0, 0, 3'b000, "bp_hold");
            chk("bp_dout", dout,           held);
            chk("bp_port", 32'(dout_port), 32'd2);
            chk("bp_vld",  32'(dout_vld),  32'd1);
        end
        cyc(3'b111, 1, 0, 3'b001, "bp_release");

        // Reset while holding an unaccepted word; port 0 wins first afterwards.
        dout_ack = 1'b0;
        do_reset("rst_mid");
        cyc(3'b111, 1, 0, 3'b001, "post_rst");

        // Port 2 exhausts its 64 credits, then gets skipped.
        for (int i = 0; i < 64; i++) cyc(3'b100, 1, 0, 3'b100, "exh");
        cyc(3'b100, 1, 0, 3'b000, "exh65");
        cyc(3'b111, 1, 0, 3'b001, "skip0");
        cyc(3'b111, 1, 0, 3'b010, "skip1");
        cyc(3'b111, 1, 0, 3'b001, "skip2");
        cyc(3'b000, 1, 3'b100, 3'b000, "ret2");
        cyc(3'b100, 1, 0, 3'b100, "one_more");
        cyc(3'b100, 1, 0, 3'b000, "none_more");
        cyc(3'b000, 1, 0, 3'b000, "drain1");
        chk("exh_err", 32'(cred_err), 32'd0);

        // Grant and return on port 0 together leave it at the maximum.
        do_reset("rst_e1");
        cyc(3'b001, 1, 3'b001, 3'b001, "coinc");
        cyc(3'b000, 1, 0, 3'b000, "drain2");
        chk("coinc_err", 32'(cred_err), 32'd0);
        cyc(3'b000, 1, 3'b001, 3'b000, "ret0_full");
        chk("ret0_err", 32'(cred_err), 32'd1);

        // Overflow on port 1 is sticky until reset.
        do_reset("rst_e2");
        cyc(3'b000, 1, 3'b010, 3'b000, "ret1_full");
        chk("ovf_err", 32'(cred_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000, 1, 0, 3'b000, "sticky");
            chk("sticky_err", 32'(cred_err), 32'd1);
        end
        do_reset("rst_end");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
